water_inlet_arbiter: RTL and testbench

Shares the single building water supply valve between up to N washing machine controllers. Each machine raises its water-inlet request (its o_waterinlet output) into this block. The block grants the valve to exactly one machine at a time, using round-robin priority and a bounded fill slot. Between grants it inserts a valve settling gap, and it withdraws all grants while the supply is reported bad.

---
 rtl/water_inlet_arbiter.sv | 142 ++++++++++++++
 tb/tb_water_inlet_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter that shares one water supply valve between N_MACH machines,
// with a bounded fill slot, a closed-valve settling gap and a supply-fault inhibit.
module water_inlet_arbiter #(
  parameter int unsigned N_MACH      = 4,
  parameter int unsigned FILL_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [N_MACH-1:0]                i_req,
  input  logic                             i_supply_ok,
  output logic [N_MACH-1:0]                o_grant,
  output logic                             o_valve_open,
  output logic [N_MACH-1:0]                o_wait,
  output logic                             o_timeout,
  output logic [$clog2(FILL_CYCLES+1)-1:0] o_fill_cnt
);

  localparam int unsigned PW = $clog2(N_MACH);
  localparam int unsigned CW = $clog2(FILL_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] LastIdx = PW'(N_MACH - 1);
  localparam logic [CW-1:0] FillMax = CW'(FILL_CYCLES);
  localparam logic [GW-1:0] GapMax  = GW'(GAP_CYCLES);
  localparam logic [PW:0]   NumMach = (PW + 1)'(N_MACH);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e             state_q, state_d;
  logic [N_MACH-1:0]  grant_q, grant_d;
  logic [CW-1:0]      fill_q, fill_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic               timeout_q, timeout_d;

  logic [PW:0]        cand;
  logic [PW-1:0]      win_idx;
  logic               win_found;
  logic [PW-1:0]      ptr_after_owner;

  // First requester at or after ptr, wrapping modulo N_MACH.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_MACH; i++) begin
      cand = {1'b0, ptr_q} + (PW + 1)'(i);
      if (cand >= NumMach) begin
        cand = cand - NumMach;
      end
      if (!win_found && i_req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign ptr_after_owner = (owner_q == LastIdx) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    fill_d    = fill_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_supply_ok && win_found) begin
          state_d          = StGrant;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          fill_d           = CW'(1);
        end
      end

      StGrant: begin
        if (!i_supply_ok || !i_req[owner_q] || (fill_q == FillMax)) begin
          state_d = StGap;
          grant_d = '0;
          fill_d  = '0;
          gap_d   = GW'(1);
          // A supply fault leaves ptr alone so the interrupted owner keeps priority.
          if (i_supply_ok) begin
            ptr_d     = ptr_after_owner;
            timeout_d = i_req[owner_q];
          end
        end else begin
          fill_d = fill_q + CW'(1);
        end
      end

      StGap: begin
        if (gap_q >= GapMax) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
        fill_d  = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      fill_q    <= '0;
      gap_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      fill_q    <= fill_d;
      gap_q     <= gap_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_valve_open = |grant_q;
  assign o_wait       = i_req & ~grant_q;
  assign o_timeout    = timeout_q;
  assign o_fill_cnt   = fill_q;

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Directed and randomized bench for water_inlet_arbiter; every cycle is checked
// against an integer-level reference model of the arbitration rules.
module tb_water_inlet_arbiter;

  localparam int N = 4;
  localparam int F = 8;
  localparam int G = 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         sup;
  logic [N-1:0] grant;
  logic         valve;
  logic [N-1:0] wait_o;
  logic         timeout;
  logic [3:0]   fill;

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 = none), cycles held, gap cycles left, priority pointer.
  int m_owner, m_fill, m_gap, m_ptr, m_to;

  water_inlet_arbiter #(
    .N_MACH      (N),
    .FILL_CYCLES (F),
    .GAP_CYCLES  (G)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_supply_ok  (sup),
    .o_grant      (grant),
    .o_valve_open (valve),
    .o_wait       (wait_o),
    .o_timeout    (timeout),
    .o_fill_cnt   (fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_fill  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_to    = 0;
  endtask

  task automatic release_owner(input bit advance, input bit to);
    if (advance) m_ptr = (m_owner + 1) % N;
    m_owner = -1;
    m_fill  = 0;
    m_gap   = G;
    m_to    = to ? 1 : 0;
  endtask

  task automatic model_step();
    m_to = 0;
    if (m_owner >= 0) begin
      if (!sup)                release_owner(1'b0, 1'b0);
      else if (!req[m_owner])  release_owner(1'b1, 1'b0);
      else if (m_fill == F)    release_owner(1'b1, 1'b1);
      else                     m_fill++;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (sup && req != '0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && req[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_fill  = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    check("grant", 32'(grant), 32'(g));
    check("valve", 32'(valve), 32'(m_owner >= 0));
    check("wait", 32'(wait_o), 32'(req & ~g));
    check("timeout", 32'(timeout), 32'(m_to));
    check("fill_cnt", 32'(fill), 32'(m_fill));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_outputs();
  endtask

  // Called at posedge+1; holds reset across one edge and releases between edges.
  task automatic do_reset();
    req = '0;
    sup = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    tick();
    #3 rst_n = 1'b1;
  endtask

  logic [N-1:0] prev_g;
  logic [N-1:0] starts[$];
  logic [N-1:0] exp_rr[5];
  int           n_to;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    sup   = 1'b1;
    model_reset();
    #3;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valve", 32'(valve), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_fill", 32'(fill), 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // Single machine, short fill: released by drop, no timeout, ptr moves to 1.
    req = 4'b0001;
    repeat (3) tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_fill3", 32'(fill), 32'd3);
    req = 4'b0000;
    tick();
    check("t1_gap_grant", 32'(grant), 32'h0);
    check("t1_no_timeout", 32'(timeout), 32'h0);
    tick();
    req = 4'b1111;
    tick();
    check("t1_ptr_next", 32'(grant), 32'h2);

    // Round-robin with all requesting.
    do_reset();
    req       = 4'b1111;
    exp_rr    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    starts    = {};
    n_to      = 0;
    prev_g    = grant;
    repeat (45) begin
      tick();
      if (prev_g == '0 && grant != '0) starts.push_back(grant);
      if (timeout) n_to++;
      prev_g = grant;
    end
    check("rr_count", 32'(starts.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (starts.size() > i) check("rr_order", 32'(starts[i]), 32'(exp_rr[i]));
    end
    check("rr_timeouts", 32'(n_to), 32'd4);

    // Timeout fairness between two requesters.
    do_reset();
    req = 4'b0011;
    tick();
    check("fair_m0", 32'(grant), 32'h1);
    check("fair_wait", 32'(wait_o), 32'h2);
    repeat (10) tick();
    check("fair_m1", 32'(grant), 32'h2);
    repeat (10) tick();
    check("fair_m0_again", 32'(grant), 32'h1);

    // Supply fault mid-grant: m2 keeps priority over m1 afterwards.
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0100;
    tick();
    check("sup_m2", 32'(grant), 32'h4);
    repeat (3) tick();
    check("sup_fill4", 32'(fill), 32'd4);
    req = 4'b0110;
    sup = 1'b0;
    repeat (5) begin
      tick();
      check("sup_fault_closed", 32'(grant), 32'h0);
    end
    sup = 1'b1;
    tick();
    check("sup_regrant_m2", 32'(grant), 32'h4);
    check("sup_fill_restart", 32'(fill), 32'd1);

    // Drop coinciding with the timeout edge counts as a drop.
    do_reset();
    req = 4'b0001;
    repeat (8) tick();
    check("dt_fill8", 32'(fill), 32'd8);
    req = 4'b0000;
    tick();
    check("dt_no_timeout", 32'(timeout), 32'h0);
    check("dt_closed", 32'(grant), 32'h0);
    tick();
    req = 4'b0011;
    tick();
    check("dt_ptr1", 32'(grant), 32'h2);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 4'b0110;
    repeat (3) tick();
    check("ar_pre", 32'(grant), 32'h2);
    #3 rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_valve", 32'(valve), 32'h0);
    model_reset();
    check_outputs();
    #2 rst_n = 1'b1;
    tick();
    check("ar_lowest", 32'(grant), 32'h2);

    // Randomized traffic against the model.
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      sup = ($urandom_range(0, 19) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
